// File: rtl/iir_coeff_ctrl.sv
// Double-buffered biquad coefficient store. Writes go to the shadow bank, and a
// commit copies the whole shadow bank into the active bank on the next sample tick.
module iir_coeff_ctrl #(
  parameter int STAGE_CNT  = 8,
  parameter int COEFF_SIZE = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [7:0]                           wr_stage,
  input  logic [2:0]                           wr_sel,
  input  logic [COEFF_SIZE-1:0]                wr_data,
  input  logic                                 commit,
  input  logic                                 sample_tick,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_a1,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_a2,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b0,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b1,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b2,
  output logic                                 busy,
  output logic                                 apply_done,
  output logic                                 err,
  input  logic                                 err_clr,
  output logic [7:0]                           apply_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic [8:0] STAGE_LIM = 9'(STAGE_CNT);

  state_t state;
  state_t state_next;
  logic   ready_en;
  logic   handshake;
  logic   addr_ok;

  // Bank index order: 0=a1, 1=a2, 2=b0, 3=b1, 4=b2 (matches wr_sel encoding)
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] shadow [5];
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] active [5];

  assign handshake = wr_valid & wr_ready;
  assign addr_ok   = ({1'b0, wr_stage} < STAGE_LIM) && (wr_sel <= 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  // ready_en keeps wr_ready low until the first clock after reset release
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = ready_en;
        if (commit) state_next = ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (sample_tick) state_next = APPLY;
      end
      APPLY: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) shadow[k] <= '0;
    end else if (handshake && addr_ok) begin
      for (int k = 0; k < 5; k++) begin
        for (int s = 0; s < STAGE_CNT; s++) begin
          if (wr_sel == 3'(k) && wr_stage == 8'(s)) shadow[k][s] <= wr_data;
        end
      end
    end
  end

  // Whole-bank copy so every stage switches on the same sample boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) active[k] <= '0;
      apply_done <= 1'b0;
      apply_cnt  <= 8'd0;
    end else begin
      apply_done <= (state == APPLY);
      if (state == APPLY) begin
        for (int k = 0; k < 5; k++) active[k] <= shadow[k];
        apply_cnt <= apply_cnt + 8'd1;
      end
    end
  end

  // A new invalid write wins over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (handshake && !addr_ok) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign coeff_a1 = active[0];
  assign coeff_a2 = active[1];
  assign coeff_b0 = active[2];
  assign coeff_b1 = active[3];
  assign coeff_b2 = active[4];

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Directed bench for iir_coeff_ctrl: a write-vector table plus hand-written
// sequences for commit timing, hold-off, error flag, counter wrap and reset abort.
module tb_iir_coeff_ctrl;

  localparam int STAGE_CNT  = 8;
  localparam int COEFF_SIZE = 16;

  logic                                 clk;
  logic                                 rst_n;
  logic                                 wr_valid;
  logic                                 wr_ready;
  logic [7:0]                           wr_stage;
  logic [2:0]                           wr_sel;
  logic [COEFF_SIZE-1:0]                wr_data;
  logic                                 commit;
  logic                                 sample_tick;
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_a1;
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_a2;
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b0;
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b1;
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b2;
  logic                                 busy;
  logic                                 apply_done;
  logic                                 err;
  logic                                 err_clr;
  logic [7:0]                           apply_cnt;

  iir_coeff_ctrl #(
    .STAGE_CNT (STAGE_CNT),
    .COEFF_SIZE(COEFF_SIZE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_stage   (wr_stage),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .commit     (commit),
    .sample_tick(sample_tick),
    .coeff_a1   (coeff_a1),
    .coeff_a2   (coeff_a2),
    .coeff_b0   (coeff_b0),
    .coeff_b1   (coeff_b1),
    .coeff_b2   (coeff_b2),
    .busy       (busy),
    .apply_done (apply_done),
    .err        (err),
    .err_clr    (err_clr),
    .apply_cnt  (apply_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  stage;
    logic [2:0]  sel;
    logic [15:0] data;
    logic        exp_err;
  } wr_vec_t;

  wr_vec_t     vec [8];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_sh  [5][8];
  logic [15:0] exp_act [5][8];
  logic [7:0]  exp_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] stage,
                                input logic [2:0] sel, input logic [15:0] data,
                                input logic cmt, input logic tick, input logic clr);
    wr_valid    = valid;
    wr_stage    = stage;
    wr_sel      = sel;
    wr_data     = data;
    commit      = cmt;
    sample_tick = tick;
    err_clr     = clr;
    step();
    wr_valid    = 1'b0;
    wr_stage    = 8'd0;
    wr_sel      = 3'd0;
    wr_data     = 16'd0;
    commit      = 1'b0;
    sample_tick = 1'b0;
    err_clr     = 1'b0;
  endtask

  // Single write from IDLE; the model only records in-range addresses
  task automatic do_write(input logic [7:0] stage, input logic [2:0] sel,
                          input logic [15:0] data);
    apply_stimulus(1'b1, stage, sel, data, 1'b0, 1'b0, 1'b0);
    if (stage < 8 && sel <= 3'd4) exp_sh[sel][stage[2:0]] = data;
  endtask

  task automatic model_apply();
    exp_act = exp_sh;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++)
      for (int s = 0; s < 8; s++) begin
        exp_sh[k][s]  = 16'd0;
        exp_act[k][s] = 16'd0;
      end
    exp_cnt = 8'd0;
  endtask

  function automatic logic [15:0] get_coeff(input int sel, input int stage);
    case (sel)
      0:       return coeff_a1[stage];
      1:       return coeff_a2[stage];
      2:       return coeff_b0[stage];
      3:       return coeff_b1[stage];
      default: return coeff_b2[stage];
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 5; k++)
      for (int s = 0; s < 8; s++)
        check_output($sformatf("%s_c%0d_s%0d", tag, k, s), get_coeff(k, s), exp_act[k][s]);
  endtask

  // commit in IDLE, tick while ARMED, then the APPLY cycle
  task automatic commit_and_apply();
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    check_output("apply_done_early", apply_done, 1'b0);
    step();
    model_apply();
    check_output("apply_done_pulse", apply_done, 1'b1);
    check_output("apply_cnt", apply_cnt, exp_cnt);
  endtask

  initial begin
    vec[0] = '{8'd8,   3'd0, 16'hDEAD, 1'b1};
    vec[1] = '{8'd1,   3'd5, 16'hBAD1, 1'b1};
    vec[2] = '{8'd7,   3'd4, 16'h7777, 1'b0};
    vec[3] = '{8'd0,   3'd1, 16'h0A0A, 1'b0};
    vec[4] = '{8'd255, 3'd2, 16'hFFFF, 1'b1};
    vec[5] = '{8'd5,   3'd3, 16'hBEEF, 1'b0};
    vec[6] = '{8'd2,   3'd7, 16'hCAFE, 1'b1};
    vec[7] = '{8'd4,   3'd0, 16'h1357, 1'b0};

    model_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_stage = 8'd0; wr_sel = 3'd0; wr_data = 16'd0;
    commit = 1'b0; sample_tick = 1'b0; err_clr = 1'b0;

    // Reset state
    #12;
    check_output("rst_wr_ready", wr_ready, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_apply_done", apply_done, 1'b0);
    check_output("rst_err", err, 1'b0);
    check_output("rst_apply_cnt", apply_cnt, 8'd0);
    check_all("rst");
    step();
    rst_n = 1'b1;
    check_output("rel_wr_ready_low", wr_ready, 1'b0);
    step();
    check_output("rel_wr_ready_high", wr_ready, 1'b1);

    // Write without commit: ticks must not move it to active
    do_write(8'd3, 3'd2, 16'h1234);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    check_output("nocommit_b0_3", coeff_b0[3], 16'h0000);
    check_output("nocommit_cnt", apply_cnt, 8'd0);
    check_output("nocommit_done", apply_done, 1'b0);

    // Write, commit, tick five cycles later
    do_write(8'd0, 3'd0, 16'h4000);
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    check_output("armed_busy", busy, 1'b1);
    check_output("armed_wr_ready", wr_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("wait_busy", busy, 1'b1);
    end
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    check_output("apply_busy", busy, 1'b1);
    check_output("apply_done_n1", apply_done, 1'b0);
    check_output("apply_a1_0_old", coeff_a1[0], 16'h0000);
    step();
    model_apply();
    check_output("upd_a1_0", coeff_a1[0], 16'h4000);
    check_output("upd_b0_3", coeff_b0[3], 16'h1234);
    check_output("upd_done", apply_done, 1'b1);
    check_output("upd_cnt", apply_cnt, 8'd1);
    check_output("upd_busy", busy, 1'b0);
    step();
    check_output("done_one_cycle", apply_done, 1'b0);

    // wr_valid held through ARMED/APPLY lands only back in IDLE
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_stage = 8'd2; wr_sel = 3'd3; wr_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      check_output("hold_wr_ready", wr_ready, 1'b0);
      step();
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_output("hold_apply_ready", wr_ready, 1'b0);
    step();
    model_apply();
    check_output("hold_idle_ready", wr_ready, 1'b1);
    check_output("hold_b1_2_not_yet", coeff_b1[2], 16'h0000);
    step();
    wr_valid = 1'b0;
    exp_sh[3][2] = 16'h5555;
    check_all("hold");
    commit_and_apply();
    check_output("hold_b1_2_applied", coeff_b1[2], 16'h5555);

    // Table of valid and invalid addresses
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      check_output($sformatf("vec%0d_err_clr", i), err, 1'b0);
      check_output($sformatf("vec%0d_ready", i), wr_ready, 1'b1);
      do_write(vec[i].stage, vec[i].sel, vec[i].data);
      check_output($sformatf("vec%0d_err", i), err, vec[i].exp_err);
    end
    commit_and_apply();
    check_all("vec");

    do_write(8'd8, 3'd1, 16'h0BAD);
    check_output("err_set", err, 1'b1);
    apply_stimulus(1'b1, 8'd9, 3'd0, 16'h0BAD, 1'b0, 1'b0, 1'b1);
    check_output("err_clr_vs_invalid", err, 1'b1);
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    check_output("err_cleared", err, 1'b0);

    // Commit and tick in the same cycle: only the next tick applies
    do_write(8'd6, 3'd2, 16'h2468);
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b1, 1'b1, 1'b0);
    check_output("same_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("same_no_done", apply_done, 1'b0);
      check_output("same_b0_6_old", coeff_b0[6], 16'h0000);
    end
    check_output("same_cnt_hold", apply_cnt, exp_cnt);
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    step();
    model_apply();
    check_output("same_b0_6_new", coeff_b0[6], 16'h2468);
    check_output("same_done", apply_done, 1'b1);
    check_output("same_cnt", apply_cnt, exp_cnt);

    // Apply count wrap
    while (exp_cnt != 8'd0) commit_and_apply();
    check_output("wrap_cnt_zero", apply_cnt, 8'd0);
    check_all("wrap");

    // Reset while ARMED aborts the commit
    do_write(8'd8, 3'd0, 16'h0001);
    do_write(8'd6, 3'd1, 16'h6666);
    apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    check_output("pre_rst_busy", busy, 1'b1);
    check_output("pre_rst_err", err, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("arst_busy", busy, 1'b0);
    check_output("arst_ready", wr_ready, 1'b0);
    check_output("arst_err", err, 1'b0);
    check_output("arst_cnt", apply_cnt, 8'd0);
    check_all("arst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 8'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0);
      check_output("post_rst_no_done", apply_done, 1'b0);
      check_output("post_rst_busy", busy, 1'b0);
    end
    commit_and_apply();
    check_all("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
